shift_unit_arbiter: RTL

Shares one `shift_op_alu` shift datapath between two issue lanes (port 0, port 1) of the execute stage. Each lane presents a shift request over a valid/ready handshake. A round-robin arbiter grants at most one request per cycle, evaluates it through the shift datapath, and writes the result into a 2-entry response FIFO. Requests that are not legal shift encodings are flagged.

---
 rtl/shift_unit_arbiter_if.sv | 50 +++++
 rtl/shift_unit_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter_if.sv
// Request/response bundle between the two execute-stage issue lanes and the
// shared shift unit. Lane signals carry a _0/_1 suffix for port 0/1.
interface shift_unit_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             req_valid_0;
  logic             req_valid_1;
  logic             req_ready_0;
  logic             req_ready_1;
  logic [31:0]      op1_0;
  logic [31:0]      op1_1;
  logic [31:0]      op2_0;
  logic [31:0]      op2_1;
  logic [6:0]       opcode_0;
  logic [6:0]       opcode_1;
  logic [2:0]       func3_0;
  logic [2:0]       func3_1;
  logic [6:0]       func7_0;
  logic [6:0]       func7_1;
  logic [31:0]      imm_0;
  logic [31:0]      imm_1;
  logic [TAG_W-1:0] tag_0;
  logic [TAG_W-1:0] tag_1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_port;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;

  modport master (
    output req_valid_0, req_valid_1,
    output op1_0, op1_1, op2_0, op2_1,
    output opcode_0, opcode_1, func3_0, func3_1, func7_0, func7_1,
    output imm_0, imm_1, tag_0, tag_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid, rsp_result, rsp_port, rsp_tag, rsp_illegal,
    output rsp_ready
  );

  modport slave (
    input  req_valid_0, req_valid_1,
    input  op1_0, op1_1, op2_0, op2_1,
    input  opcode_0, opcode_1, func3_0, func3_1, func7_0, func7_1,
    input  imm_0, imm_1, tag_0, tag_1,
    output req_ready_0, req_ready_1,
    output rsp_valid, rsp_result, rsp_port, rsp_tag, rsp_illegal,
    input  rsp_ready
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin sharing of one SLL/SRL/SRA(I) datapath between two issue lanes,
// with results queued in a 2-entry response FIFO.
module shift_unit_arbiter #(
  parameter int TAG_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  shift_unit_arbiter_if.slave bus
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [2:0] F3_SL   = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;

  typedef struct packed {
    logic [31:0]      result;
    logic             port;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  // Decode and evaluate one lane request; illegal encodings yield a zero result.
  function automatic entry_t eval_req(
    input logic             port,
    input logic [31:0]      op1,
    input logic [31:0]      op2,
    input logic [6:0]       opcode,
    input logic [2:0]       func3,
    input logic [6:0]       func7,
    input logic [31:0]      imm,
    input logic [TAG_W-1:0] tag
  );
    entry_t     e;
    logic [6:0] sel;
    logic [4:0] shamt;
    logic       legal;
    logic       right;
    logic       arith;
    e       = '0;
    e.port  = port;
    e.tag   = tag;
    sel     = F7_ZERO;
    shamt   = 5'd0;
    legal   = 1'b0;
    right   = 1'b0;
    arith   = 1'b0;
    case (opcode)
      OPC_R: begin
        sel   = func7;
        shamt = op2[4:0];
        legal = 1'b1;
      end
      OPC_I: begin
        sel   = imm[11:5];
        shamt = imm[4:0];
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    case (func3)
      F3_SL: legal = legal & (sel == F7_ZERO);
      F3_SR: begin
        right = 1'b1;
        arith = (sel == F7_ALT);
        legal = legal & ((sel == F7_ZERO) | (sel == F7_ALT));
      end
      default: legal = 1'b0;
    endcase
    e.illegal = ~legal;
    if (!legal) begin
      e.result = 32'd0;
    end else if (!right) begin
      e.result = op1 << shamt;
    end else if (arith) begin
      e.result = 32'($signed(op1) >>> shamt);
    end else begin
      e.result = op1 >> shamt;
    end
    return e;
  endfunction

  logic [1:0] count_r;
  logic       rd_ptr_r;
  logic       prio_r;
  entry_t     mem_r [2];

  logic       grant_0_s;
  logic       grant_1_s;
  logic       can_accept_s;
  logic       push_s;
  logic       pop_s;
  logic       wr_ptr_s;
  entry_t     entry_0_s;
  entry_t     entry_1_s;
  entry_t     push_entry_s;
  entry_t     head_s;

  // Arbitration, datapath evaluation and FIFO handshake decode.
  always_comb begin
    can_accept_s = (count_r != 2'd2) & ~rst;
    grant_0_s    = bus.req_valid_0 & (~bus.req_valid_1 | ~prio_r);
    grant_1_s    = bus.req_valid_1 & (~bus.req_valid_0 | prio_r);
    push_s       = can_accept_s & (grant_0_s | grant_1_s);
    pop_s        = (count_r != 2'd0) & bus.rsp_ready;
    // The write slot sits one past the head only when one entry is held.
    wr_ptr_s     = rd_ptr_r ^ count_r[0];
    entry_0_s    = eval_req(1'b0, bus.op1_0, bus.op2_0, bus.opcode_0, bus.func3_0,
                            bus.func7_0, bus.imm_0, bus.tag_0);
    entry_1_s    = eval_req(1'b1, bus.op1_1, bus.op2_1, bus.opcode_1, bus.func3_1,
                            bus.func7_1, bus.imm_1, bus.tag_1);
    if (grant_1_s) begin
      push_entry_s = entry_1_s;
    end else begin
      push_entry_s = entry_0_s;
    end
    head_s = mem_r[rd_ptr_r];
  end

  assign bus.req_ready_0 = can_accept_s & grant_0_s;
  assign bus.req_ready_1 = can_accept_s & grant_1_s;
  assign bus.rsp_valid   = (count_r != 2'd0);
  assign bus.rsp_result  = head_s.result;
  assign bus.rsp_port    = head_s.port;
  assign bus.rsp_tag     = head_s.tag;
  assign bus.rsp_illegal = head_s.illegal;

  // FIFO storage, occupancy, read pointer and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      prio_r   <= 1'b0;
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_s] <= push_entry_s;
        prio_r          <= grant_0_s;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
